// File: rtl/panel_i2c_target.sv
// panel_i2c_target: I2C target giving the HPS byte-wide access to the front-panel register file.
// SCL/SDA are synchronized and glitch-filtered before feeding the START/STOP detector and transaction FSM.
module panel_i2c_target #(
  parameter logic [6:0] ADDR   = 7'h42,
  parameter int         FILTER = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_IGNORE, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK
  } state_t;

  logic [1:0] sclSync_q, sdaSync_q;
  logic [7:0] sclCnt_q, sdaCnt_q;
  logic       sclF_q, sdaF_q, sclPrev_q, sdaPrev_q;

  state_t     state_q, state_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] regAddr_q, regAddr_d;
  logic [7:0] regWdata_q, regWdata_d;
  logic       rw_q, rw_d;
  logic       sdaOe_q, sdaOe_d;
  logic       regWe_q, regWe_d;
  logic       regRe_q, regRe_d;
  logic       busy_q, busy_d;
  logic       rdLoad_q;

  logic       sclRise, sclFall, startCond, stopCond;
  logic [7:0] rxByte;

  // The filtered level only follows the synced level once it has disagreed for FILTER cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclSync_q <= 2'b11;
      sdaSync_q <= 2'b11;
      sclCnt_q  <= '0;
      sdaCnt_q  <= '0;
      sclF_q    <= 1'b1;
      sdaF_q    <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[0], scl_i};
      sdaSync_q <= {sdaSync_q[0], sda_i};
      sclPrev_q <= sclF_q;
      sdaPrev_q <= sdaF_q;
      if (sclSync_q[1] == sclF_q) begin
        sclCnt_q <= '0;
      end else if (sclCnt_q == 8'(FILTER - 1)) begin
        sclF_q   <= sclSync_q[1];
        sclCnt_q <= '0;
      end else begin
        sclCnt_q <= sclCnt_q + 8'd1;
      end
      if (sdaSync_q[1] == sdaF_q) begin
        sdaCnt_q <= '0;
      end else if (sdaCnt_q == 8'(FILTER - 1)) begin
        sdaF_q   <= sdaSync_q[1];
        sdaCnt_q <= '0;
      end else begin
        sdaCnt_q <= sdaCnt_q + 8'd1;
      end
    end
  end

  assign sclRise   = sclF_q & ~sclPrev_q;
  assign sclFall   = ~sclF_q & sclPrev_q;
  assign startCond = sclF_q & sclPrev_q & sdaPrev_q & ~sdaF_q;
  assign stopCond  = sclF_q & sclPrev_q & ~sdaPrev_q & sdaF_q;
  assign rxByte    = {shift_q[6:0], sdaF_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      regAddr_q  <= '0;
      regWdata_q <= '0;
      rw_q       <= 1'b0;
      sdaOe_q    <= 1'b0;
      regWe_q    <= 1'b0;
      regRe_q    <= 1'b0;
      busy_q     <= 1'b0;
      rdLoad_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      regAddr_q  <= regAddr_d;
      regWdata_q <= regWdata_d;
      rw_q       <= rw_d;
      sdaOe_q    <= sdaOe_d;
      regWe_q    <= regWe_d;
      regRe_q    <= regRe_d;
      busy_q     <= busy_d;
      rdLoad_q   <= regRe_q;
    end
  end

  // ACK states use sdaOe_q as the phase marker: first SCL fall drives the ACK, second fall ends it.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    regAddr_d  = regAddr_q;
    regWdata_d = regWdata_q;
    rw_d       = rw_q;
    sdaOe_d    = sdaOe_q;
    regWe_d    = 1'b0;
    regRe_d    = 1'b0;
    busy_d     = busy_q;
    if (rdLoad_q) shift_d = reg_rdata;
    if (stopCond) begin
      state_d  = S_IDLE;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
    end else if (startCond) begin
      state_d  = S_ADDR;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d = '0;
              if (state_q == S_PTR) begin
                state_d = S_PTR_ACK;
              end else if (state_q == S_WDATA) begin
                state_d    = S_WDATA_ACK;
                regWdata_d = rxByte;
                regWe_d    = 1'b1;
              end else if (rxByte[7:1] == ADDR) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rxByte[0];
                regRe_d = rxByte[0];
              end else begin
                state_d = S_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (sclFall) begin
            if (!sdaOe_q) begin
              sdaOe_d = 1'b1;
            end else if (state_q == S_ADDR_ACK && rw_q) begin
              state_d = S_RDATA;
              sdaOe_d = ~shift_q[7];
            end else begin
              sdaOe_d = 1'b0;
              if (state_q == S_ADDR_ACK) state_d = S_PTR;
              else state_d = S_WDATA;
              if (state_q == S_PTR_ACK) regAddr_d = shift_q;
              if (state_q == S_WDATA_ACK) regAddr_d = regAddr_q + 8'd1;
            end
          end
        end
        S_RDATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd0) begin
              sdaOe_d = ~shift_q[7];
            end else if (bitCnt_q == 4'd8) begin
              sdaOe_d  = 1'b0;
              bitCnt_d = '0;
              state_d  = S_MACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sdaOe_d = ~shift_q[6];
            end
          end
        end
        S_MACK: begin
          if (sclRise) begin
            if (!sdaF_q) begin
              regAddr_d = regAddr_q + 8'd1;
              regRe_d   = 1'b1;
              state_d   = S_RDATA;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        S_IGNORE: sdaOe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe    = sdaOe_q;
  assign reg_addr  = regAddr_q;
  assign reg_wdata = regWdata_q;
  assign reg_we    = regWe_q;
  assign reg_re    = regRe_q;
  assign busy      = busy_q;

endmodule
